// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: scan timing and round-robin display arbitration for a
// 4-digit multiplexed seven-segment display shared by two requesters.
// The prescaler drives the digit scan. Ownership changes only on frame
// boundaries, and each owner keeps the display for a minimum number of frames.
// The shadow register freezes the owner's value for a whole frame.
module seg_display_scheduler #(
    parameter int DIV_W       = 15,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_a,
    input  logic [15:0] val_a,
    input  logic        req_b,
    input  logic [15:0] val_b,
    input  logic        lz_en,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  digit,
    output logic [3:0]  anode_sig,
    output logic        frame_tick
);

    // hold_cnt only needs to reach HOLD_FRAMES-1; keep at least one bit
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [1:0]        idx_q, idx_d;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              last_q, last_d;      // 1: B was granted most recently
    logic [15:0]       shadow_q, shadow_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic [3:0]        anode_q, anode_d;
    logic [3:0]        digit_q, digit_d;
    logic              frame_tick_q, frame_tick_d;

    logic       tick;
    logic       boundary;
    logic [3:0] hi_zero;                    // nibbles i..3 of the next shadow are all zero

    assign tick     = &presc_q;
    assign boundary = tick && (idx_q == 2'd3);

    // Digit 0 is never blanked, so a value of zero still shows a single "0"
    for (genvar gi = 0; gi < 4; gi++) begin : g_hi_zero
        if (gi == 0) begin : g_d0
            assign hi_zero[gi] = 1'b0;
        end else begin : g_dn
            assign hi_zero[gi] = ~|shadow_d[15:4*gi];
        end
    end

    // Scan timing, ownership arbitration and shadow capture at frame boundaries
    always_comb begin
        presc_d      = presc_q + 1'b1;
        idx_d        = idx_q;
        state_d      = state_q;
        hold_d       = hold_q;
        last_d       = last_q;
        shadow_d     = shadow_q;
        frame_tick_d = boundary;

        if (tick) begin
            idx_d = idx_q + 2'd1;
        end

        if (boundary) begin
            case (state_q)
                IDLE: begin
                    hold_d = '0;
                    if (req_a && req_b) begin
                        state_d = last_q ? OWN_A : OWN_B;
                    end else if (req_a) begin
                        state_d = OWN_A;
                    end else if (req_b) begin
                        state_d = OWN_B;
                    end
                end
                OWN_A: begin
                    if (hold_q < HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end else if (req_b) begin
                        state_d = OWN_B;
                        hold_d  = '0;
                    end else if (!req_a) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end
                OWN_B: begin
                    if (hold_q < HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end else if (req_a) begin
                        state_d = OWN_A;
                        hold_d  = '0;
                    end else if (!req_b) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase

            // A grant is any entry into an owner state from a different state
            if ((state_d != state_q) && (state_d != IDLE)) begin
                last_d = (state_d == OWN_B);
            end

            // Capture the value of the owner being entered or retained
            if (state_d == OWN_A) begin
                shadow_d = val_a;
            end else if (state_d == OWN_B) begin
                shadow_d = val_b;
            end
        end

        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
    end

    // Anode and digit for the digit being scanned next, updated on each tick
    always_comb begin
        anode_d = anode_q;
        digit_d = digit_q;
        if (tick) begin
            if (state_d == IDLE) begin
                anode_d = 4'b1111;
                digit_d = 4'h0;
            end else begin
                digit_d = shadow_d[{idx_d, 2'b00} +: 4];
                if (lz_en && hi_zero[idx_d]) begin
                    anode_d = 4'b1111;
                end else begin
                    anode_d = ~(4'b0001 << idx_d);
                end
            end
        end
    end

    // All state and outputs; clr low forces reset values at once
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            state_q      <= IDLE;
            hold_q       <= '0;
            last_q       <= 1'b1;
            shadow_q     <= 16'h0000;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            anode_q      <= 4'b1111;
            digit_q      <= 4'h0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            last_q       <= last_d;
            shadow_q     <= shadow_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            anode_q      <= anode_d;
            digit_q      <= digit_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign anode_sig  = anode_q;
    assign digit      = digit_q;
    assign frame_tick = frame_tick_q;

endmodule
